mem_access_queue: RTL

//  Non-blocking successor of the single-outstanding MEM stage. Issues loads/stores on the sram-like data bus and

---
 rtl/mem_pkg.sv | 42 ++++
 rtl/load_align.sv | 32 +++
 rtl/mem_access_queue.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared memory-stage definitions: access size encodings, op-field layout and
// store-side byte-lane helpers.
package mem_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int STRB_W = 4;

    localparam logic [1:0] MEM_SZ_B = 2'b00;
    localparam logic [1:0] MEM_SZ_H = 2'b01;
    localparam logic [1:0] MEM_SZ_W = 2'b10;

    localparam int OP_W       = 3;
    localparam int OP_SZ_LSB  = 0;
    localparam int OP_SZ_MSB  = 1;
    localparam int OP_UNS_BIT = 2;

    typedef struct packed {
        logic            we;
        logic [OP_W-1:0] op;
        logic [1:0]      addr_lo;
    } mem_meta_t;

    function automatic logic [STRB_W-1:0] size_strb(input logic [1:0] sz);
        case (sz)
            MEM_SZ_B: return 4'b0001;
            MEM_SZ_H: return 4'b0011;
            MEM_SZ_W: return 4'b1111;
            default:  return 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] replicate_wdata(input logic [1:0] sz,
                                                          input logic [DATA_W-1:0] wd);
        case (sz)
            MEM_SZ_B: return {4{wd[7:0]}};
            MEM_SZ_H: return {2{wd[15:0]}};
            default:  return wd;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Shifts raw bus read data down to the accessed byte lane and sign/zero
// extends byte and half loads.
module load_align
    import mem_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        addr_lo,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] shifted;
    logic              ext;

    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        ext     = 1'b0;
        data    = shifted;
        case (op[OP_SZ_MSB:OP_SZ_LSB])
            MEM_SZ_B: begin
                ext  = !op[OP_UNS_BIT] && shifted[7];
                data = {{24{ext}}, shifted[7:0]};
            end
            MEM_SZ_H: begin
                ext  = !op[OP_UNS_BIT] && shifted[15];
                data = {{16{ext}}, shifted[15:0]};
            end
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_queue.sv
// Non-blocking memory stage: issues up to DEPTH sram-like bus transactions,
// captures responses in request order and retires them in order toward WB.
module mem_access_queue
    import mem_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DEST_W = 5,
    parameter int PC_W   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_we,
    input  logic [OP_W-1:0]         in_op,
    input  logic [ADDR_W-1:0]       in_addr,
    input  logic [DATA_W-1:0]       in_wdata,
    input  logic [DEST_W-1:0]       in_dest,
    input  logic [PC_W-1:0]         in_pc,
    input  logic                    flush,
    output logic                    req,
    output logic                    wr,
    output logic [1:0]              size,
    output logic [ADDR_W-1:0]       addr,
    output logic [STRB_W-1:0]       wstrb,
    output logic [DATA_W-1:0]       wdata,
    input  logic                    addr_ok,
    input  logic                    data_ok,
    input  logic [DATA_W-1:0]       rdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [DEST_W-1:0]       out_dest,
    output logic                    out_we,
    output logic [PC_W-1:0]         out_pc,
    output logic [$clog2(DEPTH):0]  inflight,
    output logic                    resp_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  head_ptr, tail_ptr, resp_ptr;
    logic [CNT_W-1:0]  count;
    logic [DEPTH-1:0]  e_valid, e_done, e_poison;
    mem_meta_t         e_meta [DEPTH];
    logic [DEST_W-1:0] e_dest [DEPTH];
    logic [PC_W-1:0]   e_pc   [DEPTH];
    logic [DATA_W-1:0] e_data [DEPTH];

    logic              full, alloc, beat_ok, head_done, pop;
    logic [DATA_W-1:0] aligned;

    // Handshakes: a transfer happens in a cycle where both sides are high --
    // req&&addr_ok on the bus (mirrored as in_ready to EX), out_valid&&out_ready
    // toward WB. Valid never waits on ready; data_ok has no back-pressure.
    assign full     = (count == CNT_W'(DEPTH));
    assign req      = in_valid && !full && !flush && !rst;
    assign alloc    = req && addr_ok;
    assign in_ready = alloc;

    assign size  = in_op[OP_SZ_MSB:OP_SZ_LSB];
    assign addr  = in_addr;
    assign wstrb = in_we ? (size_strb(size) << in_addr[1:0]) : '0;
    assign wr    = |wstrb;
    assign wdata = replicate_wdata(size, in_wdata);

    // A beat only counts if the entry it lands on is still waiting for data.
    assign beat_ok   = data_ok && e_valid[resp_ptr] && !e_done[resp_ptr];
    assign head_done = e_valid[head_ptr] && e_done[head_ptr];
    assign out_valid = head_done && !e_poison[head_ptr];
    assign pop       = (out_valid && out_ready) || (head_done && e_poison[head_ptr]);

    assign out_data = e_data[head_ptr];
    assign out_dest = e_dest[head_ptr];
    assign out_we   = e_meta[head_ptr].we;
    assign out_pc   = e_pc[head_ptr];
    assign inflight = count;

    load_align u_load_align (
        .rdata   (rdata),
        .addr_lo (e_meta[resp_ptr].addr_lo),
        .op      (e_meta[resp_ptr].op),
        .data    (aligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            resp_ptr <= '0;
            count    <= '0;
            e_valid  <= '0;
            e_done   <= '0;
            e_poison <= '0;
            resp_err <= 1'b0;
        end else begin
            if (flush) begin
                e_poison <= e_poison | e_valid;
            end
            if (beat_ok) begin
                e_done[resp_ptr] <= 1'b1;
                resp_ptr         <= resp_ptr + PTR_W'(1);
            end else if (data_ok) begin
                resp_err <= 1'b1;
            end
            if (pop) begin
                e_valid[head_ptr]  <= 1'b0;
                e_done[head_ptr]   <= 1'b0;
                e_poison[head_ptr] <= 1'b0;
                head_ptr           <= head_ptr + PTR_W'(1);
            end
            // alloc never coincides with flush, and never targets the head slot while it pops.
            if (alloc) begin
                e_valid[tail_ptr]  <= 1'b1;
                e_done[tail_ptr]   <= 1'b0;
                e_poison[tail_ptr] <= 1'b0;
                tail_ptr           <= tail_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(alloc) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) begin
            e_meta[tail_ptr] <= '{we: in_we, op: in_op, addr_lo: in_addr[1:0]};
            e_dest[tail_ptr] <= in_dest;
            e_pc[tail_ptr]   <= in_pc;
        end
        if (beat_ok) begin
            e_data[resp_ptr] <= e_meta[resp_ptr].we ? '0 : aligned;
        end
    end

endmodule
